// File: rtl/ysyx_23060240_pkg.sv
// Shared types and constants for the ysyx_23060240 core.
package ysyx_23060240_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StOut,
        StWnpc
    } fetch_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060240_fetch.sv
// Instruction fetch unit: one blocking AR/R bus transaction per instruction, then hand-off to decode.
// Define IFU_FAULT_CHECK_EN to add the inst_fault output (bus error / misaligned pc detection).
module ysyx_23060240_fetch
    import ysyx_23060240_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        npc_valid,
    input  logic [31:0] npc
`ifdef IFU_FAULT_CHECK_EN
    ,
    output logic        inst_fault
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;

`ifdef IFU_FAULT_CHECK_EN
    logic err_q, err_d;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
`ifdef IFU_FAULT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef IFU_FAULT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IFU_FAULT_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StAr;
`ifdef IFU_FAULT_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    state_d = StOut;
                    inst_d  = '0;
                    err_d   = 1'b0;
                end
`endif
            end
            StAr: begin
                if (arready) state_d = StR;
            end
            StR: begin
                if (rvalid) begin
                    inst_d  = rdata;
                    state_d = StOut;
`ifdef IFU_FAULT_CHECK_EN
                    err_d   = (rresp != RESP_OKAY);
`endif
                end
            end
            StOut: begin
                if (inst_ready) state_d = StWnpc;
            end
            StWnpc: begin
                if (npc_valid) begin
                    pc_d    = npc;
                    state_d = StAr;
`ifdef IFU_FAULT_CHECK_EN
                    // Misaligned target never reaches the bus; deliver a faulting bubble.
                    if (npc[1:0] != 2'b00) begin
                        state_d = StOut;
                        inst_d  = '0;
                        err_d   = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        arvalid    = (state_q == StAr);
        araddr     = pc_q;
        rready     = (state_q == StR);
        inst_valid = (state_q == StOut);
        inst       = inst_q;
        pc         = pc_q;
`ifdef IFU_FAULT_CHECK_EN
        inst_fault = (state_q == StOut) && (err_q || (pc_q[1:0] != 2'b00));
`endif
    end

endmodule

// File: tb/tb_ysyx_23060240_fetch.sv
// Randomized self-checking bench for ysyx_23060240_fetch (honours IFU_FAULT_CHECK_EN when defined).
module tb_ysyx_23060240_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        npc_valid;
    logic [31:0] npc;
`ifdef IFU_FAULT_CHECK_EN
    logic        inst_fault;
`endif

    int vectors = 0;
    int errs    = 0;
    logic [31:0] exp_pc;
    logic [31:0] nxt;

    ysyx_23060240_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .npc_valid  (npc_valid),
        .npc        (npc)
`ifdef IFU_FAULT_CHECK_EN
        ,
        .inst_fault (inst_fault)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random traffic on inputs the current state must ignore.
    task automatic stray();
        npc_valid = 1'($urandom_range(0, 1));
        npc       = $urandom;
    endtask

    // One complete fetch as seen at the ports, ending once the new pc has been accepted.
    task automatic do_fetch(input int a_dly, input int r_dly, input int o_dly, input int w_dly,
                            input logic [31:0] data, input logic [1:0] resp,
                            input logic [31:0] next);
        for (int i = 0; i <= a_dly; i++) begin
            chk("ar_arvalid", 32'(arvalid), 32'd1);
            chk("ar_araddr", araddr, exp_pc);
            chk("ar_rready", 32'(rready), 32'd0);
            chk("ar_inst_valid", 32'(inst_valid), 32'd0);
            chk("ar_pc", pc, exp_pc);
            arready    = (i == a_dly);
            rvalid     = 1'($urandom_range(0, 1));
            rdata      = $urandom;
            rresp      = 2'($urandom);
            inst_ready = 1'($urandom_range(0, 1));
            stray();
            step();
        end
        for (int j = 0; j <= r_dly; j++) begin
            chk("r_rready", 32'(rready), 32'd1);
            chk("r_arvalid", 32'(arvalid), 32'd0);
            chk("r_inst_valid", 32'(inst_valid), 32'd0);
            arready    = 1'($urandom_range(0, 1));
            rvalid     = (j == r_dly);
            rdata      = (j == r_dly) ? data : $urandom;
            rresp      = (j == r_dly) ? resp : 2'($urandom);
            inst_ready = 1'($urandom_range(0, 1));
            stray();
            step();
        end
        arready = 1'b0;
        for (int k = 0; k <= o_dly; k++) begin
            chk("out_inst_valid", 32'(inst_valid), 32'd1);
            chk("out_inst", inst, data);
            chk("out_pc", pc, exp_pc);
            chk("out_arvalid", 32'(arvalid), 32'd0);
            chk("out_rready", 32'(rready), 32'd0);
`ifdef IFU_FAULT_CHECK_EN
            chk("out_fault", 32'(inst_fault), 32'((resp != 2'b00) || (exp_pc[1:0] != 2'b00)));
`endif
            rvalid     = 1'($urandom_range(0, 1));
            rdata      = $urandom;
            inst_ready = (k == o_dly);
            stray();
            step();
        end
        inst_ready = 1'b0;
        for (int w = 0; w <= w_dly; w++) begin
            chk("wnpc_inst_valid", 32'(inst_valid), 32'd0);
            chk("wnpc_arvalid", 32'(arvalid), 32'd0);
            chk("wnpc_pc", pc, exp_pc);
            rvalid     = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            npc_valid  = (w == w_dly);
            npc        = (w == w_dly) ? next : $urandom;
            step();
        end
        npc_valid  = 1'b0;
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        exp_pc     = next;
    endtask

    initial begin
        rst        = 1'b1;
        arready    = 1'b0;
        rdata      = '0;
        rresp      = '0;
        rvalid     = 1'b0;
        inst_ready = 1'b0;
        npc_valid  = 1'b0;
        npc        = '0;
        step();
        step();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
`ifdef IFU_FAULT_CHECK_EN
        chk("rst_fault", 32'(inst_fault), 32'd0);
`endif
        rst = 1'b0;
        step();
        exp_pc = 32'h8000_0000;

        // Minimum latency fetch, then a long arready stall, then a held decode.
        do_fetch(0, 0, 0, 0, 32'h0000_0413, 2'b00, 32'h8000_0004);
        do_fetch(5, 1, 3, 2, 32'h0010_0093, 2'b00, 32'h8000_0008);
        do_fetch(1, 2, 3, 0, 32'hdead_beef, 2'b00, 32'h8000_0004);
        chk("after_hold_araddr", araddr, 32'h8000_0004);

        // Reset while in R with a simultaneous response.
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("pre_rst_rready", 32'(rready), 32'd1);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        step();
        rst    = 1'b0;
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_pc", pc, 32'h8000_0000);
        step();
        rvalid = 1'b0;
        chk("midrst_inst_hold", inst, 32'd0);
        chk("midrst_next_arvalid", 32'(arvalid), 32'd1);
        chk("midrst_next_araddr", araddr, 32'h8000_0000);
        exp_pc = 32'h8000_0000;

`ifdef IFU_FAULT_CHECK_EN
        do_fetch(0, 0, 1, 0, 32'h0000_0013, 2'b10, 32'h8000_0002);
        chk("mis_arvalid", 32'(arvalid), 32'd0);
        chk("mis_inst_valid", 32'(inst_valid), 32'd1);
        chk("mis_inst", inst, 32'd0);
        chk("mis_fault", 32'(inst_fault), 32'd1);
        chk("mis_pc", pc, 32'h8000_0002);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        npc_valid  = 1'b1;
        npc        = 32'h8000_0100;
        step();
        npc_valid  = 1'b0;
        exp_pc     = 32'h8000_0100;
`endif

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) nxt = exp_pc + 32'd4;
            else nxt = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom, 2'($urandom), nxt);
        end
        chk("final_araddr", araddr, exp_pc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
